// File: rtl/block_stats_pkg.sv
// Shared types and default sizing for block_stats_calc.
//   stat_t          : mean/variance word for the default 8-bit pixel width
//   replay_state_e  : replay FSM states
package block_stats_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 8;
  localparam int unsigned TOTAL_SAMPLES_DEF = 64;
  localparam int unsigned LOG2_SAMPLES      = $clog2(TOTAL_SAMPLES_DEF);
  localparam int unsigned SUM_W             = DATA_WIDTH_DEF + LOG2_SAMPLES;
  localparam int unsigned SUMSQ_W           = 2 * DATA_WIDTH_DEF + LOG2_SAMPLES;

  typedef logic [2*DATA_WIDTH_DEF-1:0] stat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } replay_state_e;

endpackage

// File: rtl/block_pingpong_buf.sv
// Two-bank block buffer, simple dual-port.
//   clk                         : clock
//   wr_bank/wr_addr/wr_en/wr_data : write port
//   rd_bank/rd_addr             : read address, sampled every edge
//   rd_data                     : registered read data (1-cycle latency)
module block_pingpong_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                     clk,
  input  logic                     wr_bank,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_bank,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/block_stats_calc.sv
// Per-block mean/variance with buffered replay of the block pixels.
//   clk, rst (sync, active-high)
//   data_in/data_valid      : incoming pixel stream, gaps allowed
//   blocks_per_frame        : sampled at each block's first pixel
//   stats_ready             : 1-cycle pulse, stats valid and replay word 0 on data_out
//   mean_of_block           : floor(sum/N)
//   variance_of_block       : floor(sumsq/N) - mean^2
//   data_out/data_out_valid : replayed block, N consecutive cycles
//   frame_done              : with stats_ready of a frame's last block
//   block_index             : index of the block being replayed
module block_stats_calc
  import block_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned TOTAL_SAMPLES = TOTAL_SAMPLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  input  logic [31:0]             blocks_per_frame,
  output logic                    stats_ready,
  output logic [2*DATA_WIDTH-1:0] mean_of_block,
  output logic [2*DATA_WIDTH-1:0] variance_of_block,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic                    frame_done,
  output logic [31:0]             block_index
);

  localparam int unsigned L2N = $clog2(TOTAL_SAMPLES);
  localparam int unsigned SW  = DATA_WIDTH + L2N;
  localparam int unsigned SQW = 2 * DATA_WIDTH + L2N;
  localparam int unsigned DW2 = 2 * DATA_WIDTH;
  localparam logic [L2N-1:0] LAST = L2N'(TOTAL_SAMPLES - 1);

  // accumulator
  logic [L2N-1:0]        cnt;
  logic                  wr_bank;
  logic [SW-1:0]         sum, sum_nx;
  logic [SQW-1:0]        sumsq, sumsq_nx;
  logic [DW2-1:0]        sq;
  logic [31:0]           bpf_blk, bpf_snap;

  // snapshot / stats pipeline
  logic                  snap_valid, pipe_valid;
  logic [DATA_WIDTH-1:0] mean_snap, mean_p;
  logic [DW2-1:0]        msq_snap, msq_p, sq_p;

  // replay
  logic                  rd_bank;
  logic [L2N-1:0]        rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  replay_state_e         state, state_n;
  logic [L2N-1:0]        rcnt, rcnt_n;
  logic [DATA_WIDTH-1:0] dout_n;
  logic                  dv_n;

  // frame
  logic [31:0]           blk_cnt;
  logic                  last_of_frame;
  logic                  load;

  always_comb begin
    sq       = {{DATA_WIDTH{1'b0}}, data_in} * {{DATA_WIDTH{1'b0}}, data_in};
    sum_nx   = sum + {{L2N{1'b0}}, data_in};
    sumsq_nx = sumsq + {{L2N{1'b0}}, sq};
  end

  block_pingpong_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TOTAL_SAMPLES)
  ) u_buf (
    .clk     (clk),
    .wr_bank (wr_bank),
    .wr_addr (cnt),
    .wr_en   (data_valid),
    .wr_data (data_in),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Read address restarts at the block-end edge and free-runs, so word k is
  // captured by the buffer at E+1+k and reaches data_out at E+2+k.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      wr_bank    <= 1'b0;
      sum        <= '0;
      sumsq      <= '0;
      bpf_blk    <= '0;
      bpf_snap   <= '0;
      snap_valid <= 1'b0;
      mean_snap  <= '0;
      msq_snap   <= '0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
    end else begin
      snap_valid <= 1'b0;
      rd_addr    <= rd_addr + L2N'(1);
      if (data_valid) begin
        cnt <= cnt + L2N'(1);
        if (cnt == '0) begin
          bpf_blk <= blocks_per_frame;
        end
        if (cnt == LAST) begin
          wr_bank    <= ~wr_bank;
          sum        <= '0;
          sumsq      <= '0;
          mean_snap  <= sum_nx[SW-1:L2N];
          msq_snap   <= sumsq_nx[SQW-1:L2N];
          snap_valid <= 1'b1;
          bpf_snap   <= bpf_blk;
          rd_bank    <= wr_bank;
          rd_addr    <= '0;
        end else begin
          sum   <= sum_nx;
          sumsq <= sumsq_nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      mean_p     <= '0;
      msq_p      <= '0;
      sq_p       <= '0;
    end else begin
      pipe_valid <= snap_valid;
      if (snap_valid) begin
        mean_p <= mean_snap;
        msq_p  <= msq_snap;
        sq_p   <= {{DATA_WIDTH{1'b0}}, mean_snap} * {{DATA_WIDTH{1'b0}}, mean_snap};
      end
    end
  end

  assign load          = pipe_valid;
  assign last_of_frame = (bpf_snap != '0) && (blk_cnt == bpf_snap - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stats_ready       <= 1'b0;
      frame_done        <= 1'b0;
      mean_of_block     <= '0;
      variance_of_block <= '0;
      block_index       <= '0;
      blk_cnt           <= '0;
    end else begin
      stats_ready <= load;
      frame_done  <= 1'b0;
      if (load) begin
        mean_of_block     <= {{DATA_WIDTH{1'b0}}, mean_p};
        variance_of_block <= msq_p - sq_p;
        block_index       <= blk_cnt;
        frame_done        <= last_of_frame;
        blk_cnt           <= last_of_frame ? '0 : blk_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    dout_n  = data_out;
    dv_n    = data_out_valid;
    if (load) begin
      state_n = REPLAY;
      rcnt_n  = '0;
      dout_n  = rd_data;
      dv_n    = 1'b1;
    end else begin
      case (state)
        REPLAY: begin
          if (rcnt == LAST) begin
            state_n = IDLE;
            dv_n    = 1'b0;
          end else begin
            rcnt_n = rcnt + L2N'(1);
            dout_n = rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rcnt           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      state          <= state_n;
      rcnt           <= rcnt_n;
      data_out       <= dout_n;
      data_out_valid <= dv_n;
    end
  end

endmodule

// File: tb/tb_block_stats_calc.sv
module tb_block_stats_calc;
  import block_stats_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [31:0]   blocks_per_frame;
  logic          stats_ready;
  stat_t         mean_of_block;
  stat_t         variance_of_block;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          frame_done;
  logic [31:0]   block_index;

  always #5 clk = ~clk;

  block_stats_calc #(
    .DATA_WIDTH    (DW),
    .TOTAL_SAMPLES (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .data_valid        (data_valid),
    .blocks_per_frame  (blocks_per_frame),
    .stats_ready       (stats_ready),
    .mean_of_block     (mean_of_block),
    .variance_of_block (variance_of_block),
    .data_out          (data_out),
    .data_out_valid    (data_out_valid),
    .frame_done        (frame_done),
    .block_index       (block_index)
  );

  typedef struct {
    stat_t       mean;
    stat_t       vr;
    logic        fd;
    logic [31:0] bi;
    int unsigned at_edge;
    logic        dv0;
    logic [7:0]  d0;
  } srec_t;

  srec_t       sq[$];
  logic [7:0]  dq[$];
  int unsigned runs[$];
  logic [7:0]  exp_px[$];
  stat_t       exp_mean[$];
  stat_t       exp_var[$];
  int unsigned run_len  = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;
  int unsigned n_cmp    = 0;
  int unsigned n_err    = 0;
  logic [7:0]  blk [N];

  always @(posedge clk) cyc <= cyc + 1;

  // observation at the inactive edge
  always @(negedge clk) begin
    if (!rst && data_valid) last_acc = cyc + 1;
    if (stats_ready) begin
      srec_t r;
      r.mean = mean_of_block; r.vr = variance_of_block; r.fd = frame_done;
      r.bi = block_index; r.at_edge = cyc; r.dv0 = data_out_valid; r.d0 = data_out;
      sq.push_back(r);
    end
    if (data_out_valid) begin
      dq.push_back(data_out);
      run_len++;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    data_valid = v;
    data_in    = d;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic clear_obs();
    sq.delete(); dq.delete(); runs.delete();
    exp_px.delete(); exp_mean.delete(); exp_var.delete();
  endtask

  task automatic send_block(input int unsigned gap_pct);
    int unsigned s, ss, m;
    s = 0; ss = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gap_pct > 0)
        for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) drive(1'b0, 8'h00);
      drive(1'b1, blk[i]);
      s  += int'(blk[i]);
      ss += int'(blk[i]) * int'(blk[i]);
      exp_px.push_back(blk[i]);
    end
    m = s / N;
    exp_mean.push_back(stat_t'(m));
    exp_var.push_back(stat_t'(ss / N - m * m));
  endtask

  task automatic verify(input string tag, input int unsigned nblk);
    check_val({tag, "_nstats"}, sq.size(), nblk);
    for (int unsigned k = 0; k < nblk && k < sq.size(); k++) begin
      check_val({tag, "_mean"}, sq[k].mean, exp_mean[k]);
      check_val({tag, "_var"}, sq[k].vr, exp_var[k]);
      check_val({tag, "_dv_at_ready"}, sq[k].dv0, 1);
      check_val({tag, "_d0_at_ready"}, sq[k].d0, exp_px[k*N]);
    end
    check_val({tag, "_npix"}, dq.size(), exp_px.size());
    for (int unsigned i = 0; i < dq.size() && i < exp_px.size(); i++)
      check_val({tag, "_pix"}, dq[i], exp_px[i]);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; blocks_per_frame = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_stats_ready", stats_ready, 0);
    check_val("rst_mean", mean_of_block, 0);
    check_val("rst_var", variance_of_block, 0);
    check_val("rst_dout_valid", data_out_valid, 0);
    check_val("rst_dout", data_out, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_block_index", block_index, 0);
    rst = 1'b0;
    idle(2);

    // 1: constant 0x80
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = 8'h80;
    send_block(0);
    idle(70);
    check_val("t1_mean_const", sq.size() > 0 ? sq[0].mean : 16'hDEAD, 16'h0080);
    check_val("t1_var_const", sq.size() > 0 ? sq[0].vr : 16'hDEAD, 16'h0000);
    check_val("t1_latency", sq.size() > 0 ? sq[0].at_edge : 0, last_acc + 2);
    check_val("t1_runs", runs.size(), 1);
    check_val("t1_run_len", runs.size() > 0 ? runs[0] : 0, 64);
    verify("t1", 1);

    // 2: alternating 0x00 / 0xFF
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    send_block(0);
    idle(70);
    check_val("t2_mean_const", sq.size() > 0 ? sq[0].mean : 16'hDEAD, 16'h007F);
    check_val("t2_var_const", sq.size() > 0 ? sq[0].vr : 16'hDEAD, 16'h3FFF);
    verify("t2", 1);

    // 3: ramp 0..63
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = 8'(i);
    send_block(0);
    idle(70);
    check_val("t3_mean_const", sq.size() > 0 ? sq[0].mean : 16'hDEAD, 16'h001F);
    check_val("t3_var_const", sq.size() > 0 ? sq[0].vr : 16'hDEAD, 16'h0174);
    check_val("t3_run_len", runs.size() > 0 ? runs[0] : 0, 64);
    verify("t3", 1);

    // 4: ramp then 0x10, back to back
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = 8'(i);
    send_block(0);
    for (int i = 0; i < N; i++) blk[i] = 8'h10;
    send_block(0);
    idle(80);
    check_val("t4_runs", runs.size(), 1);
    check_val("t4_run_len", runs.size() > 0 ? runs[0] : 0, 128);
    check_val("t4_mean2_const", sq.size() > 1 ? sq[1].mean : 16'hDEAD, 16'h0010);
    check_val("t4_var2_const", sq.size() > 1 ? sq[1].vr : 16'hDEAD, 16'h0000);
    check_val("t4_bi0", sq.size() > 1 ? sq[0].bi : 32'hFFFF, 3);
    check_val("t4_bi1", sq.size() > 1 ? sq[1].bi : 32'hFFFF, 4);
    check_val("t4_fd_bpf0", sq.size() > 1 ? {sq[0].fd, sq[1].fd} : 2'b11, 2'b00);
    verify("t4", 2);

    // 5: random data with gaps, then aborted block
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = 8'($urandom_range(255));
    send_block(50);
    idle(70);
    verify("t5_gaps", 1);
    clear_obs();
    for (int i = 0; i < 30; i++) drive(1'b1, 8'($urandom_range(255)));
    @(posedge clk); #1; rst = 1'b1; data_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    idle(80);
    check_val("t5_abort_nstats", sq.size(), 0);
    check_val("t5_abort_npix", dq.size(), 0);
    clear_obs();
    for (int i = 0; i < N; i++) blk[i] = 8'($urandom_range(255));
    send_block(0);
    idle(70);
    verify("t5_after_rst", 1);

    // 6: frame of 3 blocks, 7 blocks sent
    @(posedge clk); #1; rst = 1'b1; blocks_per_frame = 32'd3;
    @(posedge clk); #1; rst = 1'b0;
    clear_obs();
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < N; i++) blk[i] = 8'(i * 3 + b * 17);
      send_block(0);
    end
    idle(80);
    check_val("t6_nstats", sq.size(), 7);
    for (int k = 0; k < 7 && k < sq.size(); k++) begin
      check_val("t6_frame_done", sq[k].fd, (k == 2 || k == 5) ? 1 : 0);
      check_val("t6_block_index", sq[k].bi, k % 3);
    end
    check_val("t6_run_len", runs.size() > 0 ? runs[0] : 0, 7 * 64);
    verify("t6", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
